// File: rtl/bsg_manycore_pkg.sv
// Shared types and elaboration helpers for the tile-array reset sequencer.
// No logic here; no latency and no flow control.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {RESET, HOLD, RELEASE, RUN} bsg_manycore_reset_seq_state_e;

  // clog2 that never returns 0, so a width of 1 is always legal
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Saturating up-counter with synchronous clear; clear has priority over up.
// Count visible one cycle after up/clear; never wraps, holds at max_val_p.
module bsg_counter_clear_up #(
  parameter int width_p   = 4,
  parameter int max_val_p = 15
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      count_o <= '0;
    end else if (up_i && (count_o != max_lp)) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_manycore_tile_array_reset_sequencer.sv
// Holds a tile subarray in reset, then releases columns (staggered when BSG_MANYCORE_RESET_STAGGER_EN).
// All outputs registered; soft reset accepted only in RUN, ignored (not queued) elsewhere.
module bsg_manycore_tile_array_reset_sequencer
  import bsg_manycore_pkg::*;
#(
  parameter int subarray_num_tiles_x_p = 4,
  parameter int num_tiles_x_p          = 16,
  parameter int num_tiles_y_p          = 8,
  parameter int x_cord_width_p         = 7,
  parameter int y_cord_width_p         = 7,
  parameter int pod_x_cord_width_p     = 3,
  parameter int pod_y_cord_width_p     = 4,
  parameter int x_subcord_offset_p     = 0,
  parameter int y_subcord_base_p       = 0,
  parameter int hold_cycles_p          = 16,
  parameter int stagger_cycles_p       = 2
) (
  input  logic                                                  clk_i,
  input  logic                                                  reset_n_i,
  input  logic [pod_x_cord_width_p-1:0]                         pod_x_i,
  input  logic [pod_y_cord_width_p-1:0]                         pod_y_i,
  input  logic                                                  soft_reset_v_i,
  output logic                                                  soft_reset_ready_o,
  output logic [subarray_num_tiles_x_p-1:0]                     reset_o,
  output logic [subarray_num_tiles_x_p-1:0][x_cord_width_p-1:0] global_x_o,
  output logic [subarray_num_tiles_x_p-1:0][y_cord_width_p-1:0] global_y_o,
  output logic                                                  run_o
);

  localparam int sx_lp              = subarray_num_tiles_x_p;
  localparam int x_subcord_width_lp = safe_clog2(num_tiles_x_p);
  localparam int y_subcord_width_lp = safe_clog2(num_tiles_y_p);
  localparam int cnt_width_lp       = safe_clog2(max_int(hold_cycles_p, stagger_cycles_p) + 1);
  localparam int cnt_max_lp         = max_int(hold_cycles_p, stagger_cycles_p);
  localparam logic [cnt_width_lp-1:0] hold_last_lp = cnt_width_lp'(hold_cycles_p - 1);

  if (x_cord_width_p != pod_x_cord_width_p + x_subcord_width_lp) begin : g_bad_x_width
    $error("x_cord_width_p must equal pod_x_cord_width_p + x sub-coordinate width");
  end
  if (y_cord_width_p != pod_y_cord_width_p + y_subcord_width_lp) begin : g_bad_y_width
    $error("y_cord_width_p must equal pod_y_cord_width_p + y sub-coordinate width");
  end

  bsg_manycore_reset_seq_state_e state_r, state_n;

  logic [sx_lp-1:0] reset_r, reset_next;
  logic [sx_lp-1:0][x_cord_width_p-1:0] global_x_r;
  logic [sx_lp-1:0][y_cord_width_p-1:0] global_y_r;
  logic run_r, run_next;
  logic ready_r, ready_next;
  logic enter_hold;
  logic [cnt_width_lp-1:0] hold_cnt;

  bsg_counter_clear_up #(
    .width_p  (cnt_width_lp),
    .max_val_p(cnt_max_lp)
  ) hold_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (enter_hold),
    .up_i     (state_r == HOLD),
    .count_o  (hold_cnt)
  );

`ifdef BSG_MANYCORE_RESET_STAGGER_EN
  localparam int col_width_lp = safe_clog2(sx_lp + 1);
  localparam logic [cnt_width_lp-1:0] stagger_last_lp = cnt_width_lp'(stagger_cycles_p - 1);
  localparam logic [col_width_lp-1:0] last_col_lp     = col_width_lp'(sx_lp - 1);

  logic enter_release, col_release;
  logic [cnt_width_lp-1:0] stagger_cnt;
  logic [col_width_lp-1:0] col_idx;

  bsg_counter_clear_up #(
    .width_p  (cnt_width_lp),
    .max_val_p(cnt_max_lp)
  ) stagger_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (enter_release | col_release),
    .up_i     (state_r == RELEASE),
    .count_o  (stagger_cnt)
  );

  // col_idx names the next column to release; column 0 goes on RELEASE entry
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      col_idx <= '0;
    end else if (enter_release) begin
      col_idx <= col_width_lp'(1);
    end else if (col_release) begin
      col_idx <= col_idx + col_width_lp'(1);
    end
  end
`endif

  always_comb begin
    state_n    = state_r;
    reset_next = reset_r;
    run_next   = run_r;
    ready_next = ready_r;
    enter_hold = 1'b0;
`ifdef BSG_MANYCORE_RESET_STAGGER_EN
    enter_release = 1'b0;
    col_release   = 1'b0;
`endif
    unique case (state_r)
      RESET: begin
        state_n    = HOLD;
        enter_hold = 1'b1;
        reset_next = '1;
      end
      HOLD: begin
        if (hold_cnt == hold_last_lp) begin
`ifdef BSG_MANYCORE_RESET_STAGGER_EN
          if (sx_lp > 1) begin
            state_n       = RELEASE;
            enter_release = 1'b1;
            reset_next    = reset_r << 1;
          end else begin
            state_n    = RUN;
            reset_next = '0;
            run_next   = 1'b1;
            ready_next = 1'b1;
          end
`else
          state_n    = RUN;
          reset_next = '0;
          run_next   = 1'b1;
          ready_next = 1'b1;
`endif
        end
      end
      RELEASE: begin
`ifdef BSG_MANYCORE_RESET_STAGGER_EN
        // reset_o is a thermometer code, so each release is a left shift
        if (stagger_cnt == stagger_last_lp) begin
          col_release = 1'b1;
          reset_next  = reset_r << 1;
          if (col_idx == last_col_lp) begin
            state_n    = RUN;
            run_next   = 1'b1;
            ready_next = 1'b1;
          end
        end
`else
        state_n = RUN;
`endif
      end
      RUN: begin
        if (soft_reset_v_i && ready_r) begin
          state_n    = HOLD;
          enter_hold = 1'b1;
          reset_next = '1;
          run_next   = 1'b0;
          ready_next = 1'b0;
        end
      end
      default: state_n = RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= RESET;
    end else begin
      state_r <= state_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      reset_r    <= '1;
      run_r      <= 1'b0;
      ready_r    <= 1'b0;
      global_x_r <= '0;
      global_y_r <= '0;
    end else begin
      reset_r <= reset_next;
      run_r   <= run_next;
      ready_r <= ready_next;
      if (enter_hold) begin
        for (int c = 0; c < sx_lp; c++) begin
          global_x_r[c] <= {pod_x_i, x_subcord_width_lp'(x_subcord_offset_p + c)};
          global_y_r[c] <= {pod_y_i, y_subcord_width_lp'(y_subcord_base_p)};
        end
      end
    end
  end

  assign reset_o            = reset_r;
  assign run_o              = run_r;
  assign soft_reset_ready_o = ready_r;
  assign global_x_o         = global_x_r;
  assign global_y_o         = global_y_r;

endmodule
